f_pc_fetch: RTL and testbench

//  Fetch stage: holds the program counter (PC_F) and the F/D pipeline register.

---
 rtl/f_pc_fetch_pkg.sv | 47 ++++
 rtl/f_pc_fetch_if.sv | 43 ++++
 rtl/f_pc_fetch_fd_pipe_reg.sv | 46 ++++
 rtl/f_pc_fetch.sv | 86 ++++++++
 tb/tb_f_pc_fetch.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/f_pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_fetch_pkg
//  Purpose  : Shared constants, types and the fetch-address check used by the
//             fetch stage, its F/D register and its interface.
//  Revision : 1.0 - initial release
// ============================================================================
package f_pc_fetch_pkg;

  // Address map and reset/entry points
  localparam logic [31:0] RESET_PC         = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC       = 32'h0000_4180;
  localparam logic [31:0] DEFAULT_IM_BASE  = 32'h0000_3000;
  localparam int unsigned DEFAULT_IM_WORDS = 4096;

  // Exception codes carried alongside the fetched word
  typedef logic [4:0] exc_t;
  localparam exc_t EXC_NONE = 5'd0;
  localparam exc_t EXC_ADEL = 5'd4;

  // All-zero word doubles as the pipeline nop
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Contents of the F/D pipeline register
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    exc_t        exc;
    logic        bd;
    logic        valid;
  } fd_t;

  // Address-error check on a fetch address. The limit is one past the last
  // legal byte and is 33 bits wide so a memory ending at 4 GiB cannot wrap.
  function automatic exc_t fetch_check(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [32:0] limit);
    exc_t exc;
    exc = EXC_NONE;
    if ((pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit)) begin
      exc = EXC_ADEL;
    end
    return exc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/f_pc_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_fetch_if
//  Purpose  : Bundle of control, instruction-memory and decode-side signals of
//             the fetch stage. "master" is the surrounding pipeline/memory,
//             "slave" is the fetch stage itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface f_pc_fetch_if;
  import f_pc_fetch_pkg::*;

  // Control from decode / CP0
  logic [31:0] NPC_D;
  logic        Stall;
  logic        Req;
  logic        Eret_D;
  logic [31:0] EPC;
  logic        D_is_jump;

  // Instruction memory
  logic [31:0] IM_rdata;
  logic [31:0] IM_addr;

  // Fetch PC and F/D register towards decode
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  exc_t        Exc_D;
  logic        BD_D;
  logic        Valid_D;

  modport master (
    output NPC_D, Stall, Req, Eret_D, EPC, D_is_jump, IM_rdata,
    input  IM_addr, PC_F, PC_D, Instr_D, Exc_D, BD_D, Valid_D
  );

  modport slave (
    input  NPC_D, Stall, Req, Eret_D, EPC, D_is_jump, IM_rdata,
    output IM_addr, PC_F, PC_D, Instr_D, Exc_D, BD_D, Valid_D
  );

endinterface
`default_nettype wire

// File: rtl/f_pc_fetch_fd_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pipe_reg
//  Purpose  : F/D pipeline register. Flush has priority over the enable so an
//             exception can squash the word even while decode is stalled.
//             A flushed entry keeps the incoming PC so decode still knows
//             where the bubble came from.
//  Revision : 1.0 - initial release
// ============================================================================
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC = f_pc_fetch_pkg::RESET_PC
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 i_en,
  input  wire logic                 i_flush,
  input  wire f_pc_fetch_pkg::fd_t  i_fd,
  output f_pc_fetch_pkg::fd_t       o_fd
);
  import f_pc_fetch_pkg::*;

  fd_t r_fd;

  // Load, flush to a bubble, or hold the F/D contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fd.pc    <= RESET_PC;
      r_fd.instr <= NOP;
      r_fd.exc   <= EXC_NONE;
      r_fd.bd    <= 1'b0;
      r_fd.valid <= 1'b0;
    end else if (i_flush) begin
      r_fd.pc    <= i_fd.pc;
      r_fd.instr <= NOP;
      r_fd.exc   <= EXC_NONE;
      r_fd.bd    <= 1'b0;
      r_fd.valid <= 1'b0;
    end else if (i_en) begin
      r_fd <= i_fd;
    end
  end

  assign o_fd = r_fd;

endmodule
`default_nettype wire

// File: rtl/f_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : f_pc_fetch
//  Purpose  : Fetch stage. Holds the fetch PC, drives instruction memory,
//             tags the fetched word with an address-error code and a
//             delay-slot flag, and hands it to decode through fd_pipe_reg.
//             No PC arithmetic is done here; PC+4 arrives in NPC_D.
//  Revision : 1.0 - initial release
// ============================================================================
module f_pc_fetch #(
  parameter logic [31:0] RESET_PC   = f_pc_fetch_pkg::RESET_PC,
  parameter logic [31:0] HANDLER_PC = f_pc_fetch_pkg::HANDLER_PC,
  parameter logic [31:0] IM_BASE    = f_pc_fetch_pkg::DEFAULT_IM_BASE,
  parameter int unsigned IM_WORDS   = f_pc_fetch_pkg::DEFAULT_IM_WORDS
) (
  input wire logic    clk,
  input wire logic    reset,
  f_pc_fetch_if.slave bus
);
  import f_pc_fetch_pkg::*;

  // One past the last legal byte address, kept in 33 bits to avoid wrap
  localparam logic [32:0] c_im_limit = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc_f;
  exc_t        w_exc_f;
  logic [31:0] w_instr_f;
  logic        w_en;
  logic        w_flush;
  fd_t         w_fd_d;
  fd_t         w_fd_q;

  // Check the fetch address and squash the memory word when it is illegal
  always_comb begin
    w_exc_f   = fetch_check(r_pc_f, IM_BASE, c_im_limit);
    w_instr_f = (w_exc_f != EXC_NONE) ? NOP : bus.IM_rdata;
  end

  // PC update: exception entry beats stall, stall beats eret and sequential
  // flow. A bad next PC is still loaded; the fault shows up only as Exc_D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_f <= RESET_PC;
    end else if (bus.Req) begin
      r_pc_f <= HANDLER_PC;
    end else if (bus.Stall) begin
      r_pc_f <= r_pc_f;
    end else if (bus.Eret_D) begin
      r_pc_f <= bus.EPC;
    end else begin
      r_pc_f <= bus.NPC_D;
    end
  end

  // F/D controls: a stalled eret must not squash the word it is waiting on
  always_comb begin
    w_en          = !bus.Stall;
    w_flush       = bus.Req | (bus.Eret_D & !bus.Stall);
    w_fd_d.pc     = r_pc_f;
    w_fd_d.instr  = w_instr_f;
    w_fd_d.exc    = w_exc_f;
    w_fd_d.bd     = bus.D_is_jump;
    w_fd_d.valid  = 1'b1;
  end

  fd_pipe_reg #(
    .RESET_PC (RESET_PC)
  ) u_fd_pipe_reg (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_en),
    .i_flush (w_flush),
    .i_fd    (w_fd_d),
    .o_fd    (w_fd_q)
  );

  assign bus.IM_addr = r_pc_f;
  assign bus.PC_F    = r_pc_f;
  assign bus.PC_D    = w_fd_q.pc;
  assign bus.Instr_D = w_fd_q.instr;
  assign bus.Exc_D   = w_fd_q.exc;
  assign bus.BD_D    = w_fd_q.bd;
  assign bus.Valid_D = w_fd_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_f_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_f_pc_fetch
//  Purpose  : Self-checking bench for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_f_pc_fetch;
  import f_pc_fetch_pkg::*;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr;
    logic [4:0]  exc;
    logic        bd;
    logic        valid;
  } st_t;

  logic clk = 1'b0;
  logic reset;
  f_pc_fetch_if bus();

  f_pc_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory image: a distinct non-zero word per address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, ~a[15:0]};
  endfunction

  assign bus.IM_rdata = mem_word(bus.IM_addr);

  // Reference state and scoreboard
  st_t         sb[$];
  logic [31:0] m_pc, m_pcd, m_instr;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;
  int          n_tests = 0;
  int          n_fail  = 0;
  st_t         exp_s, got_s;

  function automatic st_t observe();
    return '{bus.PC_F, bus.PC_D, bus.Instr_D, bus.Exc_D, bus.BD_D, bus.Valid_D};
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_pcd = 32'h3000; m_instr = 32'h0;
    m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
    sb.delete();
  endtask

  task automatic idle_inputs();
    bus.NPC_D = 32'h3000; bus.Stall = 1'b0; bus.Req = 1'b0;
    bus.Eret_D = 1'b0; bus.EPC = 32'h0; bus.D_is_jump = 1'b0;
  endtask

  // Predict the next state from the current inputs, push it, and clock once
  task automatic cycle();
    logic [4:0]  e;
    logic [31:0] w;
    e = ((m_pc[1:0] != 2'b00) || (m_pc < 32'h3000) || (m_pc >= 32'h7000)) ? 5'd4 : 5'd0;
    w = (e != 5'd0) ? 32'h0 : mem_word(m_pc);
    if (bus.Req) begin
      m_pcd = m_pc; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
      m_pc = 32'h4180;
    end else if (bus.Stall) begin
      m_pc = m_pc;
    end else if (bus.Eret_D) begin
      m_pcd = m_pc; m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0; m_valid = 1'b0;
      m_pc = bus.EPC;
    end else begin
      m_pcd = m_pc; m_instr = w; m_exc = e; m_bd = bus.D_is_jump; m_valid = 1'b1;
      m_pc = bus.NPC_D;
    end
    sb.push_back('{m_pc, m_pcd, m_instr, m_exc, m_bd, m_valid});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    got_s = observe();
    n_tests++;
    if (got_s !== st_t'({32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0})) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", got_s,
               st_t'({32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0}));
    end
    n_tests++;
    if (bus.IM_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL reset_im_addr got=%h want=%h", bus.IM_addr, 32'h3000);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bus.NPC_D = 32'h3004;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s) begin
      n_fail++;
      $display("FAIL reset_release_sb got=%h want=%h", got_s, exp_s);
    end
    n_tests++;
    if (bus.PC_F !== 32'h3004 || bus.PC_D !== 32'h3000 || bus.Valid_D !== 1'b1 ||
        bus.Instr_D !== mem_word(32'h3000)) begin
      n_fail++;
      $display("FAIL reset_release pc_f=%h pc_d=%h valid=%b instr=%h want 3004/3000/1/%h",
               bus.PC_F, bus.PC_D, bus.Valid_D, bus.Instr_D, mem_word(32'h3000));
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc_hold, instr_hold;
    bus.NPC_D = 32'h3008;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s) begin
      n_fail++;
      $display("FAIL stall_pre got=%h want=%h", got_s, exp_s);
    end
    pc_hold = 32'h3008; instr_hold = mem_word(32'h3004);
    bus.Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.NPC_D = 32'h3100 + 32'(k * 4);
      cycle();
      exp_s = sb.pop_front(); got_s = observe();
      n_tests++;
      if (got_s !== exp_s || bus.PC_F !== pc_hold || bus.Instr_D !== instr_hold) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got=%h want=%h", k, got_s, exp_s);
      end
    end
    bus.Stall = 1'b0;
    bus.NPC_D = 32'h3200;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.PC_F !== 32'h3200) begin
      n_fail++;
      $display("FAIL stall_release got=%h want=%h", got_s, exp_s);
    end
  endtask

  task automatic test_req();
    bus.Req = 1'b1; bus.Stall = 1'b1; bus.NPC_D = 32'h3300;
    cycle();
    bus.Req = 1'b0; bus.Stall = 1'b0;
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.PC_F !== 32'h4180 || bus.Instr_D !== 32'h0 ||
        bus.Valid_D !== 1'b0 || bus.PC_D !== 32'h3200) begin
      n_fail++;
      $display("FAIL req_over_stall got=%h want=%h", got_s, exp_s);
    end
  endtask

  task automatic test_eret();
    bus.NPC_D = 32'h4184;
    cycle();
    void'(sb.pop_front());
    bus.Eret_D = 1'b1; bus.EPC = 32'h3010; bus.NPC_D = 32'h4188;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.PC_F !== 32'h3010 || bus.Valid_D !== 1'b0) begin
      n_fail++;
      $display("FAIL eret got=%h want=%h", got_s, exp_s);
    end
    bus.Stall = 1'b1; bus.EPC = 32'h3020;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.PC_F !== 32'h3010) begin
      n_fail++;
      $display("FAIL eret_stalled got=%h want=%h", got_s, exp_s);
    end
    bus.Stall = 1'b0; bus.Eret_D = 1'b0;
  endtask

  task automatic test_exc();
    logic [31:0] addr [5] = '{32'h3002, 32'h7000, 32'h6FFC, 32'h2FFC, 32'h3014};
    logic [4:0]  want [5] = '{5'd4, 5'd4, 5'd0, 5'd4, 5'd0};
    for (int k = 0; k < 5; k++) begin
      bus.NPC_D = addr[k];
      cycle();
      void'(sb.pop_front());
      bus.NPC_D = 32'h3000;
      cycle();
      exp_s = sb.pop_front(); got_s = observe();
      n_tests++;
      if (got_s !== exp_s || bus.Exc_D !== want[k] || bus.PC_D !== addr[k] ||
          bus.Instr_D !== ((want[k] != 5'd0) ? 32'h0 : mem_word(addr[k]))) begin
        n_fail++;
        $display("FAIL fetch_check[%h] exc=%0d want=%0d got=%h want=%h",
                 addr[k], bus.Exc_D, want[k], got_s, exp_s);
      end
    end
  endtask

  task automatic test_bd();
    bus.D_is_jump = 1'b1; bus.NPC_D = 32'h3004;
    cycle();
    bus.D_is_jump = 1'b0;
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.BD_D !== 1'b1) begin
      n_fail++;
      $display("FAIL bd_set bd=%b got=%h want=%h", bus.BD_D, got_s, exp_s);
    end
    bus.D_is_jump = 1'b1; bus.Req = 1'b1;
    cycle();
    bus.D_is_jump = 1'b0; bus.Req = 1'b0;
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s || bus.BD_D !== 1'b0) begin
      n_fail++;
      $display("FAIL bd_flush bd=%b got=%h want=%h", bus.BD_D, got_s, exp_s);
    end
  endtask

  task automatic test_reset_mid();
    bus.Stall = 1'b1; bus.NPC_D = 32'h3400;
    cycle();
    void'(sb.pop_front());
    #2 reset = 1'b1;
    #1;
    got_s = observe();
    n_tests++;
    if (got_s !== st_t'({32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0})) begin
      n_fail++;
      $display("FAIL reset_mid_stall got=%h", got_s);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle_inputs();
    bus.NPC_D = 32'h3004;
    cycle();
    exp_s = sb.pop_front(); got_s = observe();
    n_tests++;
    if (got_s !== exp_s) begin
      n_fail++;
      $display("FAIL reset_mid_resume got=%h want=%h", got_s, exp_s);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 60; k++) begin
      bus.Stall     = ($urandom_range(0, 3) == 0);
      bus.Req       = ($urandom_range(0, 9) == 0);
      bus.Eret_D    = ($urandom_range(0, 7) == 0);
      bus.D_is_jump = ($urandom_range(0, 2) == 0);
      bus.EPC       = 32'h3000 + (32'($urandom_range(0, 63)) << 2);
      case ($urandom_range(0, 9))
        0:       bus.NPC_D = 32'h3001 + 32'($urandom_range(0, 2));
        1:       bus.NPC_D = 32'h7000 + (32'($urandom_range(0, 15)) << 2);
        2:       bus.NPC_D = 32'h6FFC;
        default: bus.NPC_D = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
      endcase
      cycle();
      exp_s = sb.pop_front(); got_s = observe();
      n_tests++;
      if (got_s !== exp_s) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] got=%h want=%h", k, got_s, exp_s);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_stall();
    test_req();
    test_eret();
    test_exc();
    test_bd();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
